// File: rtl/data_memory_unit_pkg.sv
// Shared definitions for the data memory unit.
//   state_e      : controller states (ST_CLEAR wipes the array, ST_RUN serves requests)
//   DMU_DEPTH    : default number of 32-bit words
//   DMU_AW       : default word-index width (log2 of DMU_DEPTH)
//   CNT_W        : width of the saturating access counters
package data_memory_unit_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int DMU_DEPTH = 1024;
    localparam int DMU_AW    = 10;
    localparam int CNT_W     = 16;

endpackage

// File: rtl/data_memory_unit_sat.sv
// Saturating up-counter with synchronous active-high reset.
//   clk   : clock
//   rst   : synchronous reset, clears the count
//   inc   : increment enable; ignored once the count reaches all-ones
//   count : current count
module sat_counter
    import data_memory_unit_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/data_memory_unit.sv
// Word-addressed data memory for a pipeline memory stage, with a side-band
// loader write port, a power-on clear sequence, sticky error reporting and
// saturating access counters.
//   clk, rst            : clock, synchronous active-high reset
//   addr                : byte address shared by load and store
//   mem_read/mem_write  : CPU load / store request
//   wdata / rdata       : store data / combinational load data
//   ld_valid/ld_ready   : loader handshake (CPU store has priority)
//   ld_addr / ld_data   : loader word index / data
//   busy                : clear sequence in progress
//   err_misalign        : sticky, some access had addr[1:0] != 0
//   err_range           : sticky, some access fell outside the array
//   err_addr            : address of the first erroneous access
//   rd_count / wr_count : saturating counts of valid loads / stores
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int DEPTH = DMU_DEPTH,
    parameter int AW    = DMU_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     ld_addr,
    input  logic [31:0]       ld_data,
    output logic              busy,
    output logic              err_misalign,
    output logic              err_range,
    output logic [31:0]       err_addr,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [31:0] mem [DEPTH];

    state_e        state_q,        state_d;
    logic [AW-1:0] clr_ptr_q,      clr_ptr_d;
    logic          err_misalign_q, err_misalign_d;
    logic          err_range_q,    err_range_d;
    logic [31:0]   err_addr_q,     err_addr_d;

    logic          in_run;
    logic          misaligned;
    logic          out_of_range;
    logic          access_ok;
    logic [AW-1:0] word_idx;
    logic          cpu_rd;
    logic          cpu_wr;
    logic          ld_fire;
    logic          any_access;

    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign in_run       = (state_q == ST_RUN);
    assign misaligned   = (addr[1:0] != 2'b00);
    assign out_of_range = (addr[31:AW+2] != '0);
    assign access_ok    = !misaligned && !out_of_range;
    assign word_idx     = addr[AW+1:2];

    assign cpu_rd     = in_run && mem_read  && access_ok;
    assign cpu_wr     = in_run && mem_write && access_ok;
    assign any_access = in_run && (mem_read || mem_write);

    // Combinational read sees the pre-edge contents, so a same-cycle
    // store to the same word returns the old value.
    assign rdata = cpu_rd ? mem[word_idx] : 32'h0;

    // The loader only gets the write port when the CPU is not storing.
    assign ld_ready = in_run && !cpu_wr;
    assign ld_fire  = ld_valid && ld_ready;

    assign busy = (state_q == ST_CLEAR);

    // ------------------------------------------------------------------
    // Single write port: clear > CPU store > loader
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = 32'h0;
        if (!in_run) begin
            mem_we    = 1'b1;
            mem_widx  = clr_ptr_q;
            mem_wdata = 32'h0;
        end else if (cpu_wr) begin
            mem_we    = 1'b1;
            mem_widx  = word_idx;
            mem_wdata = wdata;
        end else if (ld_fire) begin
            mem_we    = 1'b1;
            mem_widx  = ld_addr;
            mem_wdata = ld_data;
        end
    end

    // Array has no reset; its contents are defined by the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky error capture; err_addr latches only the first offender.
    // ------------------------------------------------------------------
    always_comb begin
        err_misalign_d = err_misalign_q || (any_access && misaligned);
        err_range_d    = err_range_q    || (any_access && out_of_range);
        err_addr_d     = err_addr_q;
        if (!err_misalign_q && !err_range_q && any_access && !access_ok) begin
            err_addr_d = addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_CLEAR;
            clr_ptr_q      <= '0;
            err_misalign_q <= 1'b0;
            err_range_q    <= 1'b0;
            err_addr_q     <= 32'h0;
        end else begin
            state_q        <= state_d;
            clr_ptr_q      <= clr_ptr_d;
            err_misalign_q <= err_misalign_d;
            err_range_q    <= err_range_d;
            err_addr_q     <= err_addr_d;
        end
    end

    assign err_misalign = err_misalign_q;
    assign err_range    = err_range_q;
    assign err_addr     = err_addr_q;

    // ------------------------------------------------------------------
    // Access counters: index 0 counts loads, index 1 counts stores.
    // ------------------------------------------------------------------
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {cpu_wr, cpu_rd};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
        );
    end

    assign rd_count = cnt_val[0];
    assign wr_count = cnt_val[1];

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          busy;
    logic          err_misalign;
    logic          err_range;
    logic [31:0]   err_addr;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    data_memory_unit #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .wdata        (wdata),
        .rdata        (rdata),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .busy         (busy),
        .err_misalign (err_misalign),
        .err_range    (err_range),
        .err_addr     (err_addr),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    int          m_clear_left;
    int          m_rd_cnt;
    int          m_wr_cnt;
    bit          m_mis;
    bit          m_rng;
    logic [31:0] m_eaddr;

    int n_assert = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    logic [31:0] obs_rdata;
    logic        obs_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 8) return 32'($urandom_range(0, 63)) * 4;
        else if (sel == 8) return 32'($urandom_range(0, 255));
        else return $urandom;
    endfunction

    task automatic model_reset();
        m_clear_left = DEPTH;
        m_rd_cnt     = 0;
        m_wr_cnt     = 0;
        m_mis        = 0;
        m_rng        = 0;
        m_eaddr      = 32'h0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    endtask

    // One clock cycle: drive, check combinational outputs, clock, update
    // the model, check registered outputs.
    task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic lv,
                            input logic [AW-1:0] la, input logic [31:0] lw,
                            input bit verbose);
        bit          run;
        bit          ok;
        logic [31:0] exp_rd;
        bit          exp_ready;
        int          idx;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = lw;
        #1;
        run       = (m_clear_left == 0);
        ok        = addr_ok(a);
        idx       = int'(a / 4) % DEPTH;
        exp_rd    = (run && rd && ok) ? m_mem[idx] : 32'h0;
        exp_ready = run && !(wr && ok);
        obs_rdata = rdata;
        obs_ready = ld_ready;
        chk("rdata", rdata, exp_rd);
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, exp_ready});
        if (verbose) begin
            n_txn++;
            $display("txn %0d: rd=%0b wr=%0b addr=%08h wdata=%08h ld_v=%0b ld_addr=%0d ld_data=%08h -> rdata=%08h ld_ready=%0b",
                     n_txn, rd, wr, a, wd, lv, la, lw, rdata, ld_ready);
        end
        @(posedge clk);
        if (!run) begin
            m_clear_left--;
        end else begin
            if (rd && ok && m_rd_cnt < 65535) m_rd_cnt++;
            if (wr && ok) begin
                m_mem[idx] = wd;
                if (m_wr_cnt < 65535) m_wr_cnt++;
            end else if (lv) begin
                m_mem[la] = lw;
            end
            if ((rd || wr) && !ok) begin
                if (!m_mis && !m_rng) m_eaddr = a;
                if (a % 4 != 0) m_mis = 1;
                if (a >= DEPTH * 4) m_rng = 1;
            end
        end
        #1;
        chk("busy", {31'b0, busy}, {31'b0, (m_clear_left > 0)});
        chk("rd_count", {16'b0, rd_count}, 32'(m_rd_cnt));
        chk("wr_count", {16'b0, wr_count}, 32'(m_wr_cnt));
        chk("err_misalign", {31'b0, err_misalign}, {31'b0, m_mis});
        chk("err_range", {31'b0, err_range}, {31'b0, m_rng});
        chk("err_addr", err_addr, m_eaddr);
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, '0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ld_valid  = 1'b0;
        addr      = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        $display("txn reset: busy=%0b rd_count=%0d wr_count=%0d", busy, rd_count, wr_count);
        chk("rst_busy", {31'b0, busy}, 32'h1);
        chk("rst_rd_count", {16'b0, rd_count}, 32'h0);
        chk("rst_wr_count", {16'b0, wr_count}, 32'h0);
        chk("rst_err_misalign", {31'b0, err_misalign}, 32'h0);
        chk("rst_err_range", {31'b0, err_range}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'h0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        addr      = 32'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wdata     = 32'h0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = 32'h0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset, partial clear, reset again: the clear must restart in full.
        do_reset();
        repeat (100) idle_cycle();
        do_reset();

        // Count busy cycles while throwing random traffic at the unit.
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            do_cycle(1'($urandom), 1'($urandom), rand_addr(), $urandom,
                     1'($urandom), AW'($urandom_range(0, 63)), $urandom, 1'b0);
            n++;
        end
        chk("clear_length", 32'(n), 32'd1024);

        // Last word reads back zero after the clear.
        do_cycle(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 1'b0, '0, 32'h0, 1'b1);
        chk("read_last_word", obs_rdata, 32'h0);

        // Store then load.
        do_cycle(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, '0, 32'h0, 1'b1);
        do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, '0, 32'h0, 1'b1);
        chk("load_after_store", obs_rdata, 32'hDEAD_BEEF);
        chk("wr_count_one", {16'b0, wr_count}, 32'd1);
        chk("rd_count_two", {16'b0, rd_count}, 32'd2);

        // Same-cycle load and store return the old word.
        do_cycle(1'b0, 1'b1, 32'h20, 32'h11, 1'b0, '0, 32'h0, 1'b1);
        do_cycle(1'b1, 1'b1, 32'h20, 32'h22, 1'b0, '0, 32'h0, 1'b1);
        chk("rw_same_old", obs_rdata, 32'h11);
        do_cycle(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, '0, 32'h0, 1'b1);
        chk("rw_same_new", obs_rdata, 32'h22);

        // Misaligned load then out-of-range store.
        do_cycle(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, '0, 32'h0, 1'b1);
        do_cycle(1'b0, 1'b1, 32'h4000, 32'hBAD0_BAD0, 1'b0, '0, 32'h0, 1'b1);
        chk("err_misalign_set", {31'b0, err_misalign}, 32'h1);
        chk("err_range_set", {31'b0, err_range}, 32'h1);
        chk("err_addr_first", err_addr, 32'h13);
        do_cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, '0, 32'h0, 1'b1);
        chk("range_store_dropped", obs_rdata, 32'h0);

        // Loader blocked by a CPU store, then accepted.
        do_cycle(1'b0, 1'b1, 32'h30, 32'h3333, 1'b1, AW'(5), 32'hA5, 1'b1);
        chk("ld_blocked", {31'b0, obs_ready}, 32'h0);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, AW'(5), 32'hA5, 1'b1);
        chk("ld_accepted", {31'b0, obs_ready}, 32'h1);
        do_cycle(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, '0, 32'h0, 1'b1);
        chk("ld_readback", obs_rdata, 32'hA5);

        // Random mixed traffic against the model.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom), 1'($urandom), rand_addr(), $urandom,
                     1'($urandom), AW'($urandom_range(0, 63)), $urandom, 1'b1);
        end

        // Drive the load counter into saturation.
        for (int i = 0; i < 70000; i++) begin
            do_cycle(1'b1, 1'b0, 32'($urandom_range(0, DEPTH - 1)) * 4, 32'h0,
                     1'b0, '0, 32'h0, 1'b0);
        end
        chk("rd_count_saturated", {16'b0, rd_count}, 32'h0000_FFFF);

        // Reset mid-run.
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
